regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, CSR/mul) using round-robin arbitration with a valid/ready handshake. Drives a registered write command (we/rd/wd) into the register file. Keeps a per-register pending-write scoreboard that decode allocates into and queries for RAW/WAW stalls. Sits between the execute/writeback units and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
CNT_W, 16, width of the saturating conflict counter

Ports:
s_clk  in  1  clock
s_reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_rd  in  NUM_REQ x 5  destination register per requester
req_wd  in  NUM_REQ x XLEN  write data per requester
req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid && ready
rf_we  out  1  register-file write enable (registered)
rf_rd  out  5  register-file destination (registered)
rf_wd  out  XLEN  register-file write data (registered)
alloc_valid  in  1  decode marks alloc_rd as pending
alloc_rd  in  5  register being allocated
alloc_ready  out  1  allocation accepted
rs1, rs2  in  5 each  decode source-operand query
rs1_busy, rs2_busy  out  1 each  source has a pending write
fwd1_valid, fwd2_valid  out  1 each  bypass hit (optional feature)
fwd1_data, fwd2_data  out  XLEN each  bypass data
conflict_cnt  out  CNT_W  cycles with more than one req_valid (saturating)

Behaviour:
- Reset (synchronous, s_reset high at posedge): rf_we=0, rf_rd=0, rf_wd=0, scoreboard all 0, rr_ptr=0, conflict_cnt=0. req_ready is combinational and 0 while s_reset is high. Reset mid-handshake drops the pending request; the requester must re-present it.
- Arbitration (combinational): search starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester is granted; at most one bit of req_ready is high. If any request is granted, rr_ptr <= granted index + 1 mod NUM_REQ; otherwise rr_ptr holds. The port is never back-pressured, so exactly one grant occurs whenever any req_valid is high.
- Requesters hold req_valid/req_rd/req_wd stable until ready. Deasserting valid before ready is legal (request withdrawn).
- Latency: one cycle. A handshake in cycle N gives rf_we=1, rf_rd, rf_wd in cycle N+1, and the register file writes at the end of N+1. With no handshake, rf_we=0 and rf_rd/rf_wd hold their previous values.
- A granted request with rd=0 is consumed (ready=1) but produces rf_we=0.
- Scoreboard: 32 busy bits; bit 0 is hard-wired to 0.
  - Set at the posedge when alloc_valid && alloc_ready && alloc_rd!=0.
  - Cleared at the posedge ending a cycle where rf_we=1 for that rd.
  - Same edge sets and clears the same register: set wins.
- alloc_ready = !busy[alloc_rd] (WAW stall). It is 1 for rd=0, and alloc_rd=0 allocates nothing.
- rsX_busy = busy[rsX] (combinational); always 0 for rsX=0.
- conflict_cnt increments each cycle with popcount(req_valid)>1 and saturates at all-ones.

Optional Feature:
Macro REGFILE_WB_BYPASS_EN.
- Defined: when rf_we=1 and rsX==rf_rd!=0, fwdX_valid=1, fwdX_data=rf_wd, and rsX_busy=0 in that cycle.
- Undefined: fwdX_valid=0, fwdX_data=0, and rsX_busy reflects the scoreboard only.

Decomposition:
- Package regfile_pkg: XLEN_DEF=32, REG_ADDR_W=5, NUM_REGS=32, typedef reg_addr_t (logic[4:0]), typedef wb_req_t struct {valid, rd, wd}.
- One sub-module, rr_arbiter (NUM_REQ): takes the request vector and s_clk/s_reset, and outputs a one-hot grant. It owns rr_ptr.

Test Plan:
- Reset, then req0 valid with rd=5, wd=0xDEADBEEF -> req_ready=3'b001 same cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
- All three valid continuously for 6 cycles -> grants 0,1,2,0,1,2; conflict_cnt increments every cycle it sees 3 valid (reaches 6).
- alloc rd=7, then query rs1=7 -> rs1_busy=1; a second alloc rd=7 -> alloc_ready=0; after writeback of rd=7 -> busy clears the cycle after rf_we, and alloc_ready=1.
- Writeback of rd=9 in the same cycle as a new alloc of rd=9 -> busy[9]=1 afterwards (set wins).
- Request with rd=0 and alloc rd=0 -> ready=1, rf_we stays 0, rs1=0 never busy.
- With REGFILE_WB_BYPASS_EN: rf_we=1, rf_rd=4, rf_wd=0x55, rs2=4 -> fwd2_valid=1, fwd2_data=0x55, rs2_busy=0. Without the macro -> fwd2_valid=0, rs2_busy=1.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the writeback arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic                valid;
        reg_addr_t           rd;
        logic [XLEN_DEF-1:0] wd;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot arbiter; owns the rotating priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               s_clk,
    input  logic               s_reset,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic             found;

    // Grant the valid requester with the smallest rotational distance from the pointer.
    always_comb begin
        grant_o  = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        for (int d = 0; d < NUM_REQ; d++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] &&
                    (((j - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ) == d)) begin
                    found      = 1'b1;
                    grant_o[j] = 1'b1;
                    rr_ptr_d   = PTR_W'((j + 1) % NUM_REQ);
                end
            end
        end
        if (s_reset) begin
            grant_o = '0;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin writeback port sharing with pending-write scoreboard.
//               Optional bypass outputs enabled by macro REGFILE_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = XLEN_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                                 s_clk,
    input  logic                                 s_reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_rd,
    input  logic [NUM_REQ-1:0][XLEN-1:0]         req_wd,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 rf_we,
    output logic [REG_ADDR_W-1:0]                rf_rd,
    output logic [XLEN-1:0]                      rf_wd,
    input  logic                                 alloc_valid,
    input  logic [REG_ADDR_W-1:0]                alloc_rd,
    output logic                                 alloc_ready,
    input  logic [REG_ADDR_W-1:0]                rs1,
    input  logic [REG_ADDR_W-1:0]                rs2,
    output logic                                 rs1_busy,
    output logic                                 rs2_busy,
    output logic                                 fwd1_valid,
    output logic                                 fwd2_valid,
    output logic [XLEN-1:0]                      fwd1_data,
    output logic [XLEN-1:0]                      fwd2_data,
    output logic [CNT_W-1:0]                     conflict_cnt
);

    logic [NUM_REQ-1:0]    grant;
    logic                  hs;
    reg_addr_t             sel_rd;
    logic [XLEN-1:0]       sel_wd;
    logic                  seen_valid;
    logic                  multi_valid;

    logic                  rf_we_q;
    reg_addr_t             rf_rd_q;
    logic [XLEN-1:0]       rf_wd_q;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [CNT_W-1:0]      conflict_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .s_clk   (s_clk),
        .s_reset (s_reset),
        .req_i   (req_valid),
        .grant_o (grant)
    );

    assign req_ready = grant;

    always_comb begin
        hs          = 1'b0;
        sel_rd      = '0;
        sel_wd      = '0;
        seen_valid  = 1'b0;
        multi_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k] && req_valid[k]) begin
                hs     = 1'b1;
                sel_rd = req_rd[k];
                sel_wd = req_wd[k];
            end
            if (req_valid[k]) begin
                multi_valid = multi_valid | seen_valid;
                seen_valid  = 1'b1;
            end
        end
    end

    assign alloc_ready = ~busy_q[alloc_rd];

    // Set is applied after clear so a same-edge allocation of the retiring rd survives.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (alloc_valid && alloc_ready && (alloc_rd != '0)) begin
            busy_d[alloc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wd_q    <= '0;
            busy_q     <= '0;
            conflict_q <= '0;
        end else begin
            rf_we_q <= hs && (sel_rd != '0);
            if (hs) begin
                rf_rd_q <= sel_rd;
                rf_wd_q <= sel_wd;
            end
            busy_q <= busy_d;
            if (multi_valid && (conflict_q != '1)) begin
                conflict_q <= conflict_q + CNT_W'(1);
            end
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_rd        = rf_rd_q;
    assign rf_wd        = rf_wd_q;
    assign conflict_cnt = conflict_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd1_valid = rf_we_q && (rs1 == rf_rd_q) && (rs1 != '0);
    assign fwd2_valid = rf_we_q && (rs2 == rf_rd_q) && (rs2 != '0);
    assign fwd1_data  = fwd1_valid ? rf_wd_q : '0;
    assign fwd2_data  = fwd2_valid ? rf_wd_q : '0;
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

    // A bypass hit satisfies the operand this cycle, so it no longer stalls.
    assign rs1_busy = busy_q[rs1] & ~fwd1_valid;
    assign rs2_busy = busy_q[rs2] & ~fwd2_valid;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int CNT_W   = 3;

    logic                           s_clk;
    logic                           s_reset;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][4:0]        req_rd;
    logic [NUM_REQ-1:0][XLEN-1:0]   req_wd;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           rf_we;
    logic [4:0]                     rf_rd;
    logic [XLEN-1:0]                rf_wd;
    logic                           alloc_valid;
    logic [4:0]                     alloc_rd;
    logic                           alloc_ready;
    logic [4:0]                     rs1;
    logic [4:0]                     rs2;
    logic                           rs1_busy;
    logic                           rs2_busy;
    logic                           fwd1_valid;
    logic                           fwd2_valid;
    logic [XLEN-1:0]                fwd1_data;
    logic [XLEN-1:0]                fwd2_data;
    logic [CNT_W-1:0]               conflict_cnt;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN),
        .CNT_W   (CNT_W)
    ) dut (
        .s_clk        (s_clk),
        .s_reset      (s_reset),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_wd       (req_wd),
        .req_ready    (req_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .fwd1_valid   (fwd1_valid),
        .fwd2_valid   (fwd2_valid),
        .fwd1_data    (fwd1_data),
        .fwd2_data    (fwd2_data),
        .conflict_cnt (conflict_cnt)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic test_reset();
        s_reset   = 1'b1;
        req_valid = 3'b111;
        tick();
        tick();
        #1;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rf_rd); end
        total++; if (rf_wd !== 32'h0) begin bad++; $display("FAIL reset_wd got=%h exp=0", rf_wd); end
        total++; if (conflict_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
        req_valid = '0;
        s_reset   = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 3'b001;
        req_rd[0] = 5'd5;
        req_wd[0] = 32'hDEADBEEF;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", rf_we); end
        total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL single_rd got=%0d exp=5", rf_rd); end
        total++; if (rf_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wd got=%h exp=deadbeef", rf_wd); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_we_off got=%b exp=0", rf_we); end
        total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL single_rd_hold got=%0d exp=5", rf_rd); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        logic [4:0] exp_rd;
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        req_valid = 3'b111;
        req_rd[0] = 5'd1; req_rd[1] = 5'd2; req_rd[2] = 5'd3;
        req_wd[0] = 32'h100; req_wd[1] = 32'h200; req_wd[2] = 32'h300;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = 3'b001 << (i % 3);
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_g); end
            if (i > 0) begin
                exp_rd = 5'((i - 1) % 3 + 1);
                total++; if (rf_rd !== exp_rd) begin bad++; $display("FAIL rr_rd[%0d] got=%0d exp=%0d", i, rf_rd, exp_rd); end
            end
            tick();
        end
        req_valid = '0;
        #1;
        total++; if (conflict_cnt !== 3'd6) begin bad++; $display("FAIL rr_cnt got=%0d exp=6", conflict_cnt); end
        total++; if (rf_rd !== 5'd3) begin bad++; $display("FAIL rr_last_rd got=%0d exp=3", rf_rd); end
    endtask

    task automatic test_saturate_and_hold();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001;
        req_valid = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (req_ready !== exp_seq[i]) begin bad++; $display("FAIL sat_grant[%0d] got=%b exp=%b", i, req_ready, exp_seq[i]); end
            tick();
        end
        req_valid = '0;
        #1;
        total++; if (conflict_cnt !== 3'd7) begin bad++; $display("FAIL sat_cnt got=%0d exp=7", conflict_cnt); end
        tick();
        tick();
        req_valid = 3'b111;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL ptr_hold got=%b exp=010", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_scoreboard();
        logic exp_b;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL sb_alloc_ready got=%b exp=1", alloc_ready); end
        tick();
        alloc_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_rs1_busy got=%b exp=1", rs1_busy); end
        alloc_valid = 1'b1;
        #1;
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL sb_waw got=%b exp=0", alloc_ready); end
        alloc_valid = 1'b0;
        req_valid = 3'b001;
        req_rd[0] = 5'd7;
        req_wd[0] = 32'h77;
        tick();
        req_valid = '0;
        #1;
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7) begin bad++; $display("FAIL sb_wb got_we=%b got_rd=%0d exp_we=1 exp_rd=7", rf_we, rf_rd); end
`ifdef REGFILE_WB_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        total++; if (rs1_busy !== exp_b) begin bad++; $display("FAIL sb_busy_during_we got=%b exp=%b", rs1_busy, exp_b); end
        tick();
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", rs1_busy); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL sb_alloc_again got=%b exp=1", alloc_ready); end
    endtask

    task automatic test_set_wins();
        req_valid = 3'b001;
        req_rd[0] = 5'd9;
        req_wd[0] = 32'h99;
        tick();
        req_valid   = '0;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        #1;
        total++; if (rf_we !== 1'b1 || alloc_ready !== 1'b1) begin bad++; $display("FAIL setwin_pre got_we=%b got_ar=%b exp=1/1", rf_we, alloc_ready); end
        tick();
        alloc_valid = 1'b0;
        rs1 = 5'd9;
        #1;
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL setwin_busy got=%b exp=1", rs1_busy); end
    endtask

    task automatic test_rd_zero();
        req_valid   = 3'b001;
        req_rd[0]   = 5'd0;
        req_wd[0]   = 32'h1234;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rd0_ready got=%b exp=001", req_ready); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rd0_alloc_ready got=%b exp=1", alloc_ready); end
        tick();
        req_valid   = '0;
        alloc_valid = 1'b0;
        rs1 = 5'd0;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b exp=0", rf_we); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL rd0_busy got=%b exp=0", rs1_busy); end
        tick();
    endtask

    task automatic test_bypass();
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_b;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd4;
        tick();
        alloc_valid = 1'b0;
        req_valid = 3'b001;
        req_rd[0] = 5'd4;
        req_wd[0] = 32'h55;
        tick();
        req_valid = '0;
        rs1 = 5'd9;
        rs2 = 5'd4;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        exp_v = 1'b1; exp_d = 32'h55; exp_b = 1'b0;
`else
        exp_v = 1'b0; exp_d = 32'h0;  exp_b = 1'b1;
`endif
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL byp_we got=%b exp=1", rf_we); end
        total++; if (fwd2_valid !== exp_v) begin bad++; $display("FAIL byp_fwd2_valid got=%b exp=%b", fwd2_valid, exp_v); end
        total++; if (fwd2_data !== exp_d) begin bad++; $display("FAIL byp_fwd2_data got=%h exp=%h", fwd2_data, exp_d); end
        total++; if (rs2_busy !== exp_b) begin bad++; $display("FAIL byp_rs2_busy got=%b exp=%b", rs2_busy, exp_b); end
        total++; if (fwd1_valid !== 1'b0 || rs1_busy !== 1'b1) begin bad++; $display("FAIL byp_rs1 got_fwd=%b got_busy=%b exp=0/1", fwd1_valid, rs1_busy); end
        tick();
        total++; if (rs2_busy !== 1'b0 || fwd2_valid !== 1'b0) begin bad++; $display("FAIL byp_after got_busy=%b got_fwd=%b exp=0/0", rs2_busy, fwd2_valid); end
    endtask

    initial begin
        s_reset     = 1'b1;
        req_valid   = '0;
        req_rd      = '0;
        req_wd      = '0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_saturate_and_hold();
        test_scoreboard();
        test_set_wins();
        test_rd_zero();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
